// File: rtl/note_pkg.sv
// Shared constants and types for the tone/frequency-measurement path.
package note_pkg;

    localparam int unsigned FREQ_W        = 16;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 16'hFFFF;
    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } gate_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic              overflow;
        logic              no_signal;
    } meas_result_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus edge-detect flop; rise is high for one clk per input rising edge.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated-window frequency meter: counts rising edges of an async input per window,
// scales and saturates the count, and publishes one result per window.
module freq_gate_counter
    import note_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned SCALE       = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              signal_in,
    input  logic              enable,
    output logic [FREQ_W-1:0] measured_freq,
    output logic              meas_valid,
    output logic              overflow,
    output logic              no_signal
);

    localparam int unsigned TMR_W = (GATE_CYCLES > 4) ? $clog2(GATE_CYCLES) : 2;
    localparam int unsigned RES_W = CNT_W + 16;
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [1:0]       SETTLE_LAST = 2'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic rise;

    gate_state_e        state_q, state_d;
    logic [1:0]         settle_q, settle_d;
    logic [TMR_W-1:0]   gate_timer_q, gate_timer_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    meas_result_t       res_q, res_d;
    logic               valid_q, valid_d;

    logic [CNT_W-1:0]   total_c;
    logic [RES_W-1:0]   result_c;
    logic               terminal_c;

    edge_sync u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (signal_in),
        .rise     (rise)
    );

    // An edge landing on the terminal cycle still belongs to the closing window.
    always_comb begin
        total_c    = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(rise);
        result_c   = RES_W'(total_c) * RES_W'(SCALE);
        terminal_c = (state_q == GATE) && (gate_timer_q == GATE_LAST);
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        gate_timer_d = gate_timer_q;
        edge_cnt_d   = edge_cnt_q;
        res_d        = res_q;
        valid_d      = 1'b0;

        case (state_q)
            IDLE: begin
                settle_d     = '0;
                gate_timer_d = '0;
                edge_cnt_d   = '0;
                if (enable) begin
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                gate_timer_d = '0;
                edge_cnt_d   = '0;
                if (!enable) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = GATE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end

            GATE: begin
                if (terminal_c) begin
                    valid_d         = 1'b1;
                    res_d.overflow  = (result_c > RES_W'(FREQ_MAX));
                    res_d.freq      = res_d.overflow ? FREQ_MAX : FREQ_W'(result_c);
                    res_d.no_signal = (total_c == '0);
                    gate_timer_d    = '0;
                    edge_cnt_d      = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d      = IDLE;
                    gate_timer_d = '0;
                    edge_cnt_d   = '0;
                end else begin
                    gate_timer_d = gate_timer_q + TMR_W'(1);
                    edge_cnt_d   = total_c;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            gate_timer_q <= '0;
            edge_cnt_q   <= '0;
            res_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            gate_timer_q <= gate_timer_d;
            edge_cnt_q   <= edge_cnt_d;
            res_q        <= res_d;
            valid_q      <= valid_d;
        end
    end

    assign measured_freq = res_q.freq;
    assign overflow      = res_q.overflow;
    assign no_signal     = res_q.no_signal;
    assign meas_valid    = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with a short 1000-cycle gate window.
module tb_freq_gate_counter;

    localparam int unsigned G = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        signal_in;
    logic        sq_run;
    logic        sq_level;
    logic        sq_wave = 1'b0;
    int          ph = 0;

    logic [15:0] measured_freq;
    logic        meas_valid, overflow, no_signal;
    logic [15:0] sat_freq;
    logic        sat_valid, sat_overflow, sat_no_signal;

    int checks   = 0;
    int failures = 0;
    int n;
    int pulses;

    freq_gate_counter #(.GATE_CYCLES(G), .SCALE(1), .CNT_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .signal_in     (signal_in),
        .enable        (enable),
        .measured_freq (measured_freq),
        .meas_valid    (meas_valid),
        .overflow      (overflow),
        .no_signal     (no_signal)
    );

    freq_gate_counter #(.GATE_CYCLES(G), .SCALE(1000), .CNT_W(32)) dut_sat (
        .clk           (clk),
        .reset_n       (reset_n),
        .signal_in     (signal_in),
        .enable        (enable),
        .measured_freq (sat_freq),
        .meas_valid    (sat_valid),
        .overflow      (sat_overflow),
        .no_signal     (sat_no_signal)
    );

    always #5 clk = ~clk;

    // Square wave with a 10-clk period, or a constant level when sq_run is low.
    always @(posedge clk) begin
        #1;
        ph = (ph == 9) ? 0 : ph + 1;
        sq_wave = (ph < 5);
    end
    assign signal_in = sq_run ? sq_wave : sq_level;

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!meas_valid && cnt < max_cycles);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        sq_run   = 1'b0;
        sq_level = 1'b0;
        step(3);
        check("rst_freq",     32'(measured_freq), 0);
        check("rst_valid",    32'(meas_valid),    0);
        check("rst_ovf",      32'(overflow),      0);
        check("rst_nosig",    32'(no_signal),     0);
        check("rst_sat_freq", 32'(sat_freq),      0);

        reset_n = 1'b1;
        sq_run  = 1'b1;
        step(50);
        check("idle_no_valid", 32'(meas_valid), 0);

        // First window: enable sampled on the next edge, result 1003 cycles later.
        enable = 1'b1;
        step(1);
        wait_valid(G + 20, n);
        check("first_seen",   32'(meas_valid),   1);
        check("first_lat",    32'(n),            1003);
        check("first_freq",   32'(measured_freq), 100);
        check("first_ovf",    32'(overflow),     0);
        check("first_nosig",  32'(no_signal),    0);
        check("sat_freq",     32'(sat_freq),     65535);
        check("sat_ovf",      32'(sat_overflow), 1);
        check("sat_valid",    32'(sat_valid),    1);
        step(1);
        check("strobe_width", 32'(meas_valid),   0);

        // One cycle of the 1000-cycle period was spent on the width check.
        wait_valid(G + 20, n);
        check("period",       32'(n + 1),        1000);
        check("second_freq",  32'(measured_freq), 100);

        // Drop enable mid-window: partial window discarded, outputs hold.
        step(500);
        enable = 1'b0;
        pulses = 0;
        repeat (1500) begin
            step(1);
            if (meas_valid) pulses++;
        end
        check("abort_pulses", 32'(pulses),        0);
        check("abort_hold",   32'(measured_freq), 100);

        enable = 1'b1;
        step(1);
        wait_valid(G + 20, n);
        check("reen_lat",     32'(n),             1003);
        check("reen_freq",    32'(measured_freq), 100);

        // Asynchronous reset mid-window.
        step(700);
        reset_n = 1'b0;
        #1;
        check("arst_freq",    32'(measured_freq), 0);
        check("arst_sat_ovf", 32'(sat_overflow),  0);
        check("arst_sat_frq", 32'(sat_freq),      0);
        step(3);
        reset_n = 1'b1;
        step(1);
        wait_valid(G + 20, n);
        check("post_rst_lat",  32'(n),             1003);
        check("post_rst_freq", 32'(measured_freq), 100);
        check("post_rst_sat",  32'(sat_overflow),  1);

        // Constant-high input: the window in progress may see one last rise.
        sq_level = 1'b1;
        sq_run   = 1'b0;
        wait_valid(G + 20, n);
        wait_valid(G + 20, n);
        check("quiet_period", 32'(n),             1000);
        check("quiet_freq",   32'(measured_freq), 0);
        check("quiet_nosig",  32'(no_signal),     1);
        check("quiet_ovf",    32'(overflow),      0);
        check("quiet_sat",    32'(sat_overflow),  0);
        wait_valid(G + 20, n);
        check("quiet_period2", 32'(n),            1000);
        check("quiet_nosig2",  32'(no_signal),    1);

        // Single rise timed to hit the terminal gate cycle.
        sq_level = 1'b0;
        wait_valid(G + 20, n);
        step(997);
        sq_level = 1'b1;
        wait_valid(20, n);
        check("term_lat",     32'(n),             3);
        check("term_freq",    32'(measured_freq), 1);
        check("term_nosig",   32'(no_signal),     0);
        wait_valid(G + 20, n);
        check("after_term_period", 32'(n),        1000);
        check("after_term_freq",   32'(measured_freq), 0);
        check("after_term_nosig",  32'(no_signal),     1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
